// File: rtl/lcd_display_pkg.sv
// Shared types and command constants for the HD44780 write controller.
package lcd_display_pkg;

  typedef enum logic [2:0] {
    S_PWR_WAIT,
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_E_HI,
    S_HOLD,
    S_WAIT
  } state_t;

  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;
  localparam logic [7:0] CMD_LINE1    = 8'h80;
  localparam logic [7:0] CMD_LINE2    = 8'hC0;

  localparam int INIT_LEN = 4;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNC_SET;
      2'd1:    return CMD_DISP_ON;
      2'd2:    return CMD_CLEAR;
      default: return CMD_ENTRY;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_btn_debounce.sv
// Two-flop synchronizer for the write button plus an optional stability filter.
module lcd_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  input  logic en,
  output logic btn_out
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;

  // NOTE: reset is synchronous and active-high despite the name, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
      // The count only advances on consecutive cycles that disagree with the accepted level.
      if (!en || (r_sync2 == r_stable)) begin
        r_cnt <= '0;
        if (!en) r_stable <= r_sync2;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_stable <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign btn_out = en ? r_stable : r_sync2;

endmodule

// File: rtl/lcd_display.sv
// HD44780 8-bit write-only controller: power-on init, then one character per button press.
// Optional feature macro: LCD_LINE_WRAP_EN (moves the cursor to line 2 / line 1 every 16 chars).
module lcd_display
  import lcd_display_pkg::*;
#(
  parameter int POWER_ON_CYCLES   = 750000,
  parameter int E_PULSE_CYCLES    = 12,
  parameter int CMD_WAIT_CYCLES   = 2500,
  parameter int CLEAR_WAIT_CYCLES = 82000,
  parameter int DEBOUNCE_CYCLES   = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_btn,
  input  logic       button,
  input  logic       debounce_en,
  output logic       RW,
  output logic       RS,
  output logic       E,
  output logic [7:0] data
);

  localparam int MAX_WAIT = max_int(max_int(POWER_ON_CYCLES, CLEAR_WAIT_CYCLES),
                                    max_int(CMD_WAIT_CYCLES, E_PULSE_CYCLES));
  localparam int CW = $clog2(MAX_WAIT + 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] r_wait_end;
  logic [2:0]    r_init_idx;
  logic          r_rs;
  logic          r_e;
  logic [7:0]    r_data;
  logic          r_pending;
  logic [7:0]    r_char;
  logic          r_btn_prev;
`ifdef LCD_LINE_WRAP_EN
  logic [4:0]    r_char_cnt;
  logic          r_need_addr;
`endif

  logic w_btn_level;
  logic w_btn_rise;

  lcd_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .reset_n(reset_n),
    .btn_in (button),
    .en     (debounce_en),
    .btn_out(w_btn_level)
  );

  assign w_btn_rise = w_btn_level & ~r_btn_prev;

  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state     <= S_PWR_WAIT;
      r_cnt       <= '0;
      r_wait_end  <= '0;
      r_init_idx  <= '0;
      r_rs        <= 1'b0;
      r_e         <= 1'b0;
      r_data      <= 8'h00;
      r_pending   <= 1'b0;
      r_char      <= 8'h00;
      r_btn_prev  <= 1'b0;
`ifdef LCD_LINE_WRAP_EN
      r_char_cnt  <= '0;
      r_need_addr <= 1'b0;
`endif
    end else begin
      r_btn_prev <= w_btn_level;

      case (r_state)
        S_PWR_WAIT: begin
          if (r_cnt == CW'(POWER_ON_CYCLES - 1)) begin
            r_cnt   <= '0;
            r_state <= S_INIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_INIT: begin
          r_rs       <= 1'b0;
          r_data     <= init_cmd(r_init_idx[1:0]);
          r_init_idx <= r_init_idx + 1'b1;
          r_state    <= S_SETUP;
        end

        S_IDLE: begin
          if (r_pending) begin
`ifdef LCD_LINE_WRAP_EN
            // Address command goes out first; the character stays pending until the next visit.
            if (r_need_addr) begin
              r_rs        <= 1'b0;
              r_data      <= (r_char_cnt == 5'd0) ? CMD_LINE1 : CMD_LINE2;
              r_need_addr <= 1'b0;
            end else begin
              r_rs       <= 1'b1;
              r_data     <= r_char;
              r_pending  <= 1'b0;
              r_char_cnt <= r_char_cnt + 1'b1;
              if (r_char_cnt == 5'd15 || r_char_cnt == 5'd31) r_need_addr <= 1'b1;
            end
`else
            r_rs      <= 1'b1;
            r_data    <= r_char;
            r_pending <= 1'b0;
`endif
            r_state <= S_SETUP;
          end
        end

        S_SETUP: begin
          r_e     <= 1'b1;
          r_cnt   <= '0;
          r_state <= S_E_HI;
        end

        S_E_HI: begin
          if (r_cnt == CW'(E_PULSE_CYCLES - 1)) begin
            r_e     <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_HOLD;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_HOLD: begin
          r_wait_end <= (!r_rs && r_data == CMD_CLEAR) ? CW'(CLEAR_WAIT_CYCLES - 1)
                                                       : CW'(CMD_WAIT_CYCLES - 1);
          r_state    <= S_WAIT;
        end

        S_WAIT: begin
          if (r_cnt == r_wait_end) begin
            r_cnt   <= '0;
            r_state <= (r_init_idx == 3'(INIT_LEN)) ? S_IDLE : S_INIT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        default: r_state <= S_PWR_WAIT;
      endcase

      // One-deep request queue: a new edge is dropped while a character is still waiting.
      if (w_btn_rise && !r_pending) begin
        r_pending <= 1'b1;
        r_char    <= data_btn;
      end
    end
  end

  assign RW   = 1'b0;
  assign RS   = r_rs;
  assign E    = r_e;
  assign data = r_data;

endmodule

// File: tb/tb_lcd_display.sv
// Scoreboard bench for lcd_display: stimulus pushes expected LCD bytes, a monitor checks every E pulse.
module tb_lcd_display;

  localparam int P_POWER = 20;
  localparam int P_E     = 2;
  localparam int P_CMD   = 5;
  localparam int P_CLR   = 10;
  localparam int P_DEB   = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] data_btn;
  logic       button;
  logic       debounce_en;
  logic       RW, RS, E;
  logic [7:0] data;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int model_chars = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  lcd_display #(
    .POWER_ON_CYCLES  (P_POWER),
    .E_PULSE_CYCLES   (P_E),
    .CMD_WAIT_CYCLES  (P_CMD),
    .CLEAR_WAIT_CYCLES(P_CLR),
    .DEBOUNCE_CYCLES  (P_DEB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data_btn   (data_btn),
    .button     (button),
    .debounce_en(debounce_en),
    .RW         (RW),
    .RS         (RS),
    .E          (E),
    .data       (data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int wait_for(input logic [8:0] b);
    return (b == 9'h001) ? P_CLR : P_CMD;
  endfunction

  // Monitor: every rising edge of E pops one expected {RS,data} and checks the pulse timing.
  initial begin : monitor
    logic       prev_e = 1'b0;
    logic [8:0] prev_byte = '0;
    logic [8:0] hi_byte = '0;
    logic [8:0] last_byte = '0;
    int         hi_len = 0;
    int         low_len = 0;
    int         since_rst = 0;
    bit         have_last = 0;
    forever begin
      @(negedge clk);
      if (reset_n === 1'b1) begin
        prev_e    = 1'b0;
        have_last = 0;
        since_rst = 0;
        hi_len    = 0;
      end else begin
        since_rst++;
        if (E && !prev_e) begin
          pulses++;
          check("setup_valid", {RS, data}, prev_byte);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse actual=%0h required=none", {RS, data});
          end else begin
            check("byte", {RS, data}, exp_q.pop_front());
          end
          if (have_last) check_range("gap", low_len, wait_for(last_byte) + 2, 100000);
          else           check_range("power_on_wait", since_rst, P_POWER, 100000);
          hi_byte = {RS, data};
          hi_len  = 1;
        end else if (E) begin
          hi_len++;
          check("e_hi_stable", {RS, data}, hi_byte);
        end else if (prev_e) begin
          check("e_width", hi_len, P_E);
          check("hold", {RS, data}, hi_byte);
          last_byte = hi_byte;
          have_last = 1;
          low_len   = 1;
        end else begin
          low_len++;
        end
        check("rw_low", RW, 1'b0);
        prev_e    = E;
        prev_byte = {RS, data};
      end
    end
  end

  task automatic push_init();
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
    model_chars = 0;
  endtask

  // Reference model of a character write, including cursor-move commands when wrapping is built in.
  task automatic push_char(input logic [7:0] ch);
    model_chars++;
`ifdef LCD_LINE_WRAP_EN
    if (model_chars % 32 == 17) exp_q.push_back({1'b0, 8'hC0});
    if (model_chars > 32 && model_chars % 32 == 1) exp_q.push_back({1'b0, 8'h80});
`endif
    exp_q.push_back({1'b1, ch});
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
    repeat (P_CLR + 10) @(negedge clk);
  endtask

  task automatic press(input logic [7:0] ch, input logic deb);
    int settle;
    settle = deb ? P_DEB + 6 : 4;
    push_char(ch);
    @(negedge clk);
    data_btn    = ch;
    debounce_en = deb;
    button      = 1'b1;
    repeat (settle) @(negedge clk);
    button = 1'b0;
    repeat (settle) @(negedge clk);
    wait_drain();
  endtask

  initial begin : stimulus
    int p0;
    int n;
    reset_n     = 1'b1;
    button      = 1'b0;
    debounce_en = 1'b1;
    data_btn    = 8'h00;

    // Reset state
    repeat (10) begin
      @(negedge clk);
      check("rst_rs", RS, 1'b0);
      check("rst_e", E, 1'b0);
      check("rst_data", data, 8'h00);
    end
    check("rst_no_pulse", pulses, 0);

    // Power-on init sequence
    reset_n = 1'b0;
    push_init();
    wait_drain();
    check("init_pulses", pulses, 4);

    // Debounced press held down: one write, no repeats
    p0 = pulses;
    push_char(8'h83);
    data_btn    = 8'h83;
    debounce_en = 1'b1;
    button      = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!E && n < 60);
    check_range("debounce_latency", n, P_DEB + 2, P_DEB + 8);
    repeat (40) @(negedge clk);
    check("held_one_pulse", pulses, p0 + 1);
    button = 1'b0;
    repeat (P_DEB + 6) @(negedge clk);
    wait_drain();

    // Short glitch: filtered when debounced, accepted when raw
    p0 = pulses;
    data_btn = 8'h5A;
    button   = 1'b1;
    repeat (3) @(negedge clk);
    button = 1'b0;
    repeat (40) @(negedge clk);
    check("glitch_filtered", pulses, p0);
    debounce_en = 1'b0;
    push_char(8'h5A);
    button = 1'b1;
    repeat (3) @(negedge clk);
    button = 1'b0;
    repeat (4) @(negedge clk);
    wait_drain();
    check("glitch_raw_write", pulses, p0 + 1);

    // Random characters, enough to cross both line-wrap points
    for (int i = 0; i < 33; i++) begin
      press(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end

    // Reset during E high of a data write
    push_char(8'hA5);
    data_btn    = 8'hA5;
    debounce_en = 1'b0;
    button      = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!E && n < 50);
    check("mid_write_e_seen", E, 1'b1);
    #2;
    reset_n = 1'b1;
    button  = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("reset_drops_e", E, 1'b0);
    check("reset_rs", RS, 1'b0);
    check("reset_data", data, 8'h00);
    p0 = pulses;
    repeat (5) @(negedge clk);
    check("reset_no_pulse", pulses, p0);
    reset_n = 1'b0;
    push_init();
    wait_drain();
    check("reinit_pulses", pulses, p0 + 4);
    press(8'h41, 1'b1);

    check("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
